// File: rtl/issue_scoreboard.sv
// issue_scoreboard: dual-lane pending-write scoreboard; lanes A/B decode in, wb ports retire, issue/stall/busy/outstanding out
module issue_scoreboard #(
  parameter int PEND_W = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              issue_ready_i,
  input  logic              flush_i,
  input  logic              A_valid_i,
  input  logic [4:0]        A_rs1_addr_i,
  input  logic [4:0]        A_rs2_addr_i,
  input  logic [4:0]        A_rd_addr_i,
  input  logic              A_rs1_used_i,
  input  logic              A_rs2_used_i,
  input  logic              A_rd_write_i,
  input  logic              B_valid_i,
  input  logic [4:0]        B_rs1_addr_i,
  input  logic [4:0]        B_rs2_addr_i,
  input  logic [4:0]        B_rd_addr_i,
  input  logic              B_rs1_used_i,
  input  logic              B_rs2_used_i,
  input  logic              B_rd_write_i,
  input  logic [4:0]        A_wb_rd_addr_i,
  input  logic [4:0]        B_wb_rd_addr_i,
  input  logic              A_wb_write_i,
  input  logic              B_wb_write_i,
  output logic              A_issue_o,
  output logic              B_issue_o,
  output logic              stall_o,
  output logic [31:0]       busy_o,
  output logic [PEND_W+4:0] outstanding_o
);
  localparam logic [PEND_W+1:0] MAX = (PEND_W+2)'((1 << PEND_W) - 1);
  logic [31:0][PEND_W-1:0] cnt_q, cnt_d;
  logic a_wr, b_wr, raw_a, raw_b, a_full, intra, same_rd, b_cap_ok;
  assign a_wr = A_rd_write_i && A_rd_addr_i != 5'd0;
  assign b_wr = B_rd_write_i && B_rd_addr_i != 5'd0;
  assign raw_a = (A_rs1_used_i && cnt_q[A_rs1_addr_i] != '0) || (A_rs2_used_i && cnt_q[A_rs2_addr_i] != '0);
  assign raw_b = (B_rs1_used_i && cnt_q[B_rs1_addr_i] != '0) || (B_rs2_used_i && cnt_q[B_rs2_addr_i] != '0);
  assign a_full = a_wr && (PEND_W+2)'(cnt_q[A_rd_addr_i]) == MAX;
  assign intra = a_wr && ((B_rs1_used_i && B_rs1_addr_i == A_rd_addr_i) || (B_rs2_used_i && B_rs2_addr_i == A_rd_addr_i));
  assign same_rd = a_wr && A_rd_addr_i == B_rd_addr_i;
  assign b_cap_ok = !b_wr || (PEND_W+2)'(cnt_q[B_rd_addr_i]) + (PEND_W+2)'(1) + (PEND_W+2)'(same_rd) <= MAX;
  assign A_issue_o = A_valid_i && issue_ready_i && !flush_i && !reset_i && !raw_a && !a_full;
  assign B_issue_o = A_issue_o && B_valid_i && !raw_b && !intra && b_cap_ok;
  assign stall_o = A_valid_i && !A_issue_o;
  assign cnt_d[0] = '0;
  assign busy_o[0] = 1'b0;
  for (genvar r = 1; r < 32; r++) begin : g_reg
    localparam logic [4:0] R = 5'(r);
    logic [PEND_W+1:0] cur, up, dn;
    assign cur = (PEND_W+2)'(cnt_q[r]);
    assign up = (PEND_W+2)'(A_issue_o && a_wr && A_rd_addr_i == R) + (PEND_W+2)'(B_issue_o && b_wr && B_rd_addr_i == R);
    assign dn = (PEND_W+2)'(A_wb_write_i && A_wb_rd_addr_i == R) + (PEND_W+2)'(B_wb_write_i && B_wb_rd_addr_i == R);
    assign cnt_d[r] = flush_i ? '0 : PEND_W'((dn > cur ? '0 : cur - dn) + up);
    assign busy_o[r] = cnt_q[r] != '0;
  end
  always_comb begin
    outstanding_o = '0;
    for (int i = 1; i < 32; i++) outstanding_o = outstanding_o + (PEND_W+5)'(cnt_q[i]);
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed self-checking bench for issue_scoreboard
module tb_issue_scoreboard;
  logic clock_i = 1'b0, reset_i = 1'b1, issue_ready_i, flush_i;
  logic A_valid_i, A_rs1_used_i, A_rs2_used_i, A_rd_write_i;
  logic B_valid_i, B_rs1_used_i, B_rs2_used_i, B_rd_write_i;
  logic [4:0] A_rs1_addr_i, A_rs2_addr_i, A_rd_addr_i, B_rs1_addr_i, B_rs2_addr_i, B_rd_addr_i;
  logic [4:0] A_wb_rd_addr_i, B_wb_rd_addr_i;
  logic A_wb_write_i, B_wb_write_i, A_issue_o, B_issue_o, stall_o;
  logic [31:0] busy_o;
  logic [6:0] outstanding_o;
  int n_checks = 0, n_fail = 0;
  issue_scoreboard #(.PEND_W(2)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .issue_ready_i(issue_ready_i), .flush_i(flush_i),
    .A_valid_i(A_valid_i), .A_rs1_addr_i(A_rs1_addr_i), .A_rs2_addr_i(A_rs2_addr_i), .A_rd_addr_i(A_rd_addr_i),
    .A_rs1_used_i(A_rs1_used_i), .A_rs2_used_i(A_rs2_used_i), .A_rd_write_i(A_rd_write_i),
    .B_valid_i(B_valid_i), .B_rs1_addr_i(B_rs1_addr_i), .B_rs2_addr_i(B_rs2_addr_i), .B_rd_addr_i(B_rd_addr_i),
    .B_rs1_used_i(B_rs1_used_i), .B_rs2_used_i(B_rs2_used_i), .B_rd_write_i(B_rd_write_i),
    .A_wb_rd_addr_i(A_wb_rd_addr_i), .B_wb_rd_addr_i(B_wb_rd_addr_i),
    .A_wb_write_i(A_wb_write_i), .B_wb_write_i(B_wb_write_i),
    .A_issue_o(A_issue_o), .B_issue_o(B_issue_o), .stall_o(stall_o),
    .busy_o(busy_o), .outstanding_o(outstanding_o)
  );
  always #5 clock_i = ~clock_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_a(input logic v, input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2, input logic [4:0] rd, input logic w);
    A_valid_i = v; A_rs1_addr_i = s1; A_rs1_used_i = u1; A_rs2_addr_i = s2; A_rs2_used_i = u2; A_rd_addr_i = rd; A_rd_write_i = w;
  endtask
  task automatic set_b(input logic v, input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2, input logic [4:0] rd, input logic w);
    B_valid_i = v; B_rs1_addr_i = s1; B_rs1_used_i = u1; B_rs2_addr_i = s2; B_rs2_used_i = u2; B_rd_addr_i = rd; B_rd_write_i = w;
  endtask
  task automatic wb(input logic ae, input logic [4:0] aa, input logic be, input logic [4:0] ba);
    A_wb_write_i = ae; A_wb_rd_addr_i = aa; B_wb_write_i = be; B_wb_rd_addr_i = ba;
  endtask
  task automatic idle();
    set_a(0, 0, 0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0, 0, 0); wb(0, 0, 0, 0);
    issue_ready_i = 1'b1; flush_i = 1'b0;
  endtask
  task automatic tick();
    @(posedge clock_i); #1;
  endtask
  initial begin
    idle();
    set_a(1, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_out", 32'(outstanding_o), 0);
    check("rst_a_issue", 32'(A_issue_o), 0);
    check("rst_stall", 32'(stall_o), 1);
    tick(); tick();
    reset_i = 1'b0;
    idle();
    // basic RAW
    set_a(1, 0, 0, 0, 0, 3, 1); #1;
    check("raw_first_issue", 32'(A_issue_o), 1);
    tick();
    check("raw_out1", 32'(outstanding_o), 1);
    check("raw_busy3", busy_o, 32'h8);
    set_a(1, 3, 1, 0, 0, 0, 0); #1;
    check("raw_stall_issue", 32'(A_issue_o), 0);
    check("raw_stall", 32'(stall_o), 1);
    tick(); tick();
    check("raw_still_stall", 32'(A_issue_o), 0);
    wb(1, 3, 0, 0); #1;
    check("raw_no_bypass", 32'(A_issue_o), 0);
    tick();
    wb(0, 0, 0, 0); #1;
    check("raw_after_wb", 32'(A_issue_o), 1);
    check("raw_after_wb_out", 32'(outstanding_o), 0);
    tick(); idle();
    // intra-pair hazard
    set_a(1, 0, 0, 0, 0, 7, 1); set_b(1, 7, 1, 0, 0, 0, 0); #1;
    check("pair_a", 32'(A_issue_o), 1);
    check("pair_b", 32'(B_issue_o), 0);
    tick();
    check("pair_cnt7", busy_o, 32'h80);
    check("pair_out", 32'(outstanding_o), 1);
    set_a(1, 1, 1, 0, 0, 0, 0); set_b(1, 2, 1, 0, 0, 0, 0); issue_ready_i = 1'b0; #1;
    check("notready_a", 32'(A_issue_o), 0);
    check("notready_b", 32'(B_issue_o), 0);
    check("notready_stall", 32'(stall_o), 1);
    idle(); wb(0, 0, 1, 7); tick(); idle(); #1;
    check("pair_clean", 32'(outstanding_o), 0);
    // dual issue to distinct regs, dual retire
    set_a(1, 0, 0, 0, 0, 10, 1); set_b(1, 1, 1, 2, 1, 11, 1); #1;
    check("dual_b", 32'(B_issue_o), 1);
    tick(); idle(); #1;
    check("dual_busy", busy_o, 32'h0C00);
    wb(1, 10, 1, 11); tick(); idle(); #1;
    check("dual_retire", 32'(outstanding_o), 0);
    // saturation
    set_a(1, 0, 0, 0, 0, 9, 1);
    tick(); tick(); tick(); #1;
    check("sat_out3", 32'(outstanding_o), 3);
    check("sat_block", 32'(A_issue_o), 0);
    check("sat_stall", 32'(stall_o), 1);
    idle(); wb(1, 9, 0, 0); tick(); idle(); #1;
    check("sat_cnt2", 32'(outstanding_o), 2);
    set_a(1, 0, 0, 0, 0, 9, 1); set_b(1, 0, 0, 0, 0, 9, 1); #1;
    check("sat2_a", 32'(A_issue_o), 1);
    check("sat2_b", 32'(B_issue_o), 0);
    tick(); idle(); #1;
    check("sat2_out", 32'(outstanding_o), 3);
    wb(1, 9, 1, 9); tick(); idle(); #1;
    check("sat_dwb_to1", 32'(outstanding_o), 1);
    set_a(1, 0, 0, 0, 0, 9, 1); set_b(1, 0, 0, 0, 0, 9, 1); #1;
    check("sat1_b_fits", 32'(B_issue_o), 1);
    tick(); idle(); #1;
    check("sat1_out", 32'(outstanding_o), 3);
    wb(1, 9, 1, 9); tick(); idle();
    wb(1, 9, 1, 9); tick(); idle(); #1;
    check("sat_dwb_floor", 32'(outstanding_o), 0);
    // simultaneous issue+wb, stray wb, x0
    set_a(1, 0, 0, 0, 0, 4, 1); tick(); idle(); #1;
    check("sim_cnt4", 32'(outstanding_o), 1);
    set_a(1, 0, 0, 0, 0, 4, 1); wb(1, 4, 0, 0); #1;
    check("sim_issue", 32'(A_issue_o), 1);
    tick(); idle(); #1;
    check("sim_net", 32'(outstanding_o), 1);
    check("sim_busy", busy_o, 32'h10);
    wb(0, 0, 1, 12); tick(); idle(); #1;
    check("stray_wb", busy_o, 32'h10);
    set_a(1, 0, 1, 0, 1, 0, 1); wb(1, 0, 1, 0); #1;
    check("x0_src_ok", 32'(A_issue_o), 1);
    tick(); idle(); #1;
    check("x0_out", 32'(outstanding_o), 1);
    check("x0_busy", busy_o, 32'h10);
    wb(1, 4, 0, 0); tick(); idle(); #1;
    check("sim_clean", 32'(outstanding_o), 0);
    // flush
    set_a(1, 0, 0, 0, 0, 2, 1); set_b(1, 0, 0, 0, 0, 8, 1); tick();
    set_a(1, 0, 0, 0, 0, 8, 1); set_b(1, 0, 0, 0, 0, 8, 1); tick(); idle(); #1;
    check("fl_pre_out", 32'(outstanding_o), 4);
    check("fl_pre_busy", busy_o, 32'h104);
    set_a(1, 0, 0, 0, 0, 10, 1); flush_i = 1'b1; wb(1, 2, 0, 0); #1;
    check("fl_a", 32'(A_issue_o), 0);
    check("fl_b", 32'(B_issue_o), 0);
    tick(); idle(); #1;
    check("fl_out", 32'(outstanding_o), 0);
    check("fl_busy", busy_o, 0);
    // reset mid-operation
    set_a(1, 0, 0, 0, 0, 5, 1); tick(); tick(); idle(); #1;
    check("mr_out2", 32'(outstanding_o), 2);
    set_a(1, 5, 1, 0, 0, 0, 0); reset_i = 1'b1; #1;
    check("mr_busy", busy_o, 0);
    check("mr_out", 32'(outstanding_o), 0);
    check("mr_issue", 32'(A_issue_o), 0);
    check("mr_stall", 32'(stall_o), 1);
    tick();
    reset_i = 1'b0; #1;
    check("mr_after", 32'(A_issue_o), 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Dual-lane issue scoreboard for the two-wide in-order pipeline. It tracks outstanding register writes per architectural register and decides each cycle whether decode lanes A and B may issue into the shared 4-read/2-write register file. It also retires pending writes as the two writeback ports complete. It sits between decode and register-file read and drives the pipeline's issue/stall control.

## Interface
- PEND_W, 2, width of each per-register pending-write counter. Maximum outstanding writes per register is 2^PEND_W-1.
- clock_i  in  1  core clock
- reset_i  in  1  asynchronous, active-high reset
- issue_ready_i  in  1  downstream can accept an issue this cycle
- flush_i  in  1  squash all tracked pending writes
- A_valid_i, B_valid_i  in  1 each  lane holds a decoded instruction
- A_rs1_addr_i, A_rs2_addr_i, A_rd_addr_i (same for B)  in  5 each  register addresses
- A_rs1_used_i, A_rs2_used_i, A_rd_write_i (same for B)  in  1 each  operand-used / writes-rd flags
- A_wb_rd_addr_i, B_wb_rd_addr_i  in  5 each  writeback destination
- A_wb_write_i, B_wb_write_i  in  1 each  writeback commits this cycle
- A_issue_o, B_issue_o  out  1 each  lane issues this cycle
- stall_o  out  1  A_valid_i & ~A_issue_o
- busy_o  out  32  bit r = counter[r] != 0
- outstanding_o  out  PEND_W+5  sum of all counters

## Operation
- Internal state: 31 counters cnt[1..31], PEND_W bits each. Register x0 is never tracked: busy_o[0]=0; rd=0 never increments; a source of 0 never hazards.
- RAW(lane) is true if any used source s!=0 has cnt[s]!=0.
- A_issue_o = A_valid_i & issue_ready_i & ~RAW(A) & ~(A_rd_write_i & rd!=0 & cnt[rd]==max).
- B_issue_o requires A_issue_o (strict in-order), plus all of the following:
  - B_valid_i.
  - ~RAW(B).
  - No intra-pair RAW: A writes rd!=0 and rd equals a used B source.
  - Capacity: cnt[B_rd] + 1 + (A writes same rd) <= max.
- Counter update on each clock edge:
  - next = cnt + incA + incB − decA − decB.
  - inc is set by an issued lane writing that rd.
  - dec is set by a writeback port targeting that register, applied only against the current cnt. Decrement floors at 0; a stray writeback on a zero counter is ignored.
  - Two writebacks to the same register decrement by 2, floored at 0.
  - Issue and writeback on the same register in the same cycle net out (e.g. cnt=1, issue+wb → 1).
- flush_i: all counters go to 0 at the next edge. Issues and writebacks in the flush cycle are discarded. A_issue_o and B_issue_o are forced 0 while flush_i is high.
- outstanding_o is computed combinationally from the current counters.

## Timing
- Reset (async assert, sync-safe deassert) clears all counters to 0. During reset, A_issue_o=B_issue_o=0, stall_o=A_valid_i, busy_o=0, outstanding_o=0.
- Issue decisions are combinational from registered counters and current inputs, with zero latency.
- Counter changes become visible one cycle after the edge.
- No writeback bypass: a register written back at edge N is issuable from cycle N+1. This matches register-file read/write at the same edge returning the old value.
- Saturated counter (max) blocks any further writer to that rd until a writeback arrives.

## Test plan
- Reset mid-operation: cnt[5]=2, assert reset_i → busy_o=0, outstanding_o=0 immediately. After release, A reading x5 issues.
- Basic RAW: A issues writing x3 at cycle 0. Next cycle, A reads x3 → A_issue_o=0, stall_o=1. Writeback x3 at edge 4 → A_issue_o=1 in cycle 4+1.
- Intra-pair hazard: A writes x7, B reads x7 → A_issue_o=1, B_issue_o=0. Next cycle cnt[7]=1. With issue_ready_i=0, both issue outputs are 0.
- Saturation (PEND_W=2): three issued writes to x9 → cnt=3 and a fourth writer stalls. A and B both writing x9 with cnt=2 → A issues, B blocked. Double writeback to x9 at cnt=1 → cnt=0.
- Simultaneous events: cnt[4]=1, same cycle A issues write x4 and wb x4 → cnt[4]=1. A stray writeback to x12 with cnt=0 → stays 0. Writes or writebacks to x0 never change any state.
- Flush: cnt[2]=1, cnt[8]=3, flush_i with a concurrent issue to x10 → all counters 0, A_issue_o=0, outstanding_o=0 next cycle.
